// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM pin.
// The pin is synchronised into hw_clk, rising edges are detected, and each
// completed period is reported with a one-cycle meas_valid strobe. A counter
// reaching its maximum without a rising edge flags loss of signal.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2   // must be at least 2
) (
  input  logic             hw_clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    MEASURE
  } state_t;

  // Increment that sticks at CNT_MAX instead of wrapping to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   s_prev_q;
  logic                   s;
  logic                   rise;
  logic                   sync_full;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [CNT_W-1:0] hcnt_q,   hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q,   high_d;
  logic             valid_q,  valid_d;
  logic             tmo_q,    tmo_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;
  // fill_q marks when the chain carries real pin samples rather than its
  // reset zeros; without it a pin held high through reset would look like
  // a low-to-high transition once the chain filled.
  assign sync_full = fill_q[SYNC_STAGES-1];

  // Input synchroniser, fill tracker and edge-detect delay.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      sync_q   <= '0;
      fill_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      s_prev_q <= s;
    end
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge hw_clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state logic: edge-to-edge measurement with a saturation timeout.
  always_comb begin
    state_d  = state_q;
    cnt_d    = sat_inc(cnt_q);
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    tmo_d    = tmo_q;

    unique case (state_q)
      IDLE: begin
        // Only arm once the input is seen low, so an input already high
        // never produces a false first edge.
        if (sync_full && !s) begin
          state_d = ARMED;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      end
      ARMED: begin
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = CNT_ONE;
          hcnt_d  = CNT_ONE;
        end
      end
      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
          tmo_d    = 1'b0;
          cnt_d    = CNT_ONE;
          hcnt_d   = CNT_ONE;
        end else if (s) begin
          hcnt_d = sat_inc(hcnt_q);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        hcnt_d  = '0;
      end
    endcase

    // A rise coinciding with cnt==MAX wins, so period==MAX is reportable.
    if ((cnt_q == CNT_MAX) && !rise) begin
      tmo_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = tmo_q;

endmodule
